imu_sample_ram_writer: RTL and testbench



---
 rtl/imu_ram_pkg.sv | 19 +
 rtl/imu_sample_packer.sv | 39 +++
 rtl/imu_sample_ram_writer.sv | 164 ++++++++++++++++
 tb/tb_imu_sample_ram_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_ram_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the IMU sample RAM writer.
package imu_ram_pkg;

    localparam int unsigned RAM_DEPTH  = 1250;
    localparam int unsigned RAM_ADDR_W = 11;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned LANES      = 4;

    typedef enum logic {
        ST_FILL,
        ST_WRITE
    } wr_state_e;

    // Two byte lanes per 16-bit sample; count=4 gives 0xFF.
    function automatic logic [7:0] be_from_count(input logic [2:0] count);
        return 8'((9'd1 << {count, 1'b0}) - 9'd1);
    endfunction

endpackage

// File: rtl/imu_sample_packer.sv
// Accumulates 16-bit samples into a 64-bit word, lane 0 in the low bits.
module imu_sample_packer
    import imu_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  accept,
    input  logic                  clear,
    input  logic [SAMPLE_W-1:0]   sample_data,
    output logic [2:0]            fill_count,
    output logic [63:0]           word_next,
    output logic [7:0]            be_next
);

    logic [1:0]  lane_q;
    logic [63:0] data_q;

    // Next-word view includes a sample accepted this cycle so the top can
    // capture the complete word on the same edge.
    always_comb begin
        word_next = data_q;
        if (accept) begin
            word_next[{lane_q, 4'd0} +: SAMPLE_W] = sample_data;
        end
        fill_count = {1'b0, lane_q} + {2'b00, accept};
        be_next    = be_from_count(fill_count);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            lane_q <= lane_q + 2'd1;
            data_q <= word_next;
        end
    end

endmodule

// File: rtl/imu_sample_ram_writer.sv
// Packs IMU samples four per 64-bit word and writes them as an Avalon-MM master
// into a circular sample RAM, with pointer, wrap and drop status for software.
module imu_sample_ram_writer
    import imu_ram_pkg::*;
#(
    parameter int unsigned DEPTH     = RAM_DEPTH,
    parameter int unsigned ADDR_W    = RAM_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                flush,
    output logic                flush_done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [7:0]          avm_byteenable,
    output logic [63:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic                wrap,
    output logic                overflow,
    output logic [7:0]          drop_count,
    input  logic                clear_status
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

    wr_state_e   state_q, next_state;
    logic        flush_pending;
    logic        write_is_flush;
    logic        flush_req;
    logic        accept;
    logic        load_word;
    logic        flush_empty;
    logic        complete;
    logic [2:0]  fill_count;
    logic [63:0] word_next;
    logic [7:0]  be_next;

    assign flush_req = flush | flush_pending;

    imu_sample_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .accept      (accept),
        .clear       (load_word),
        .sample_data (sample_data),
        .fill_count  (fill_count),
        .word_next   (word_next),
        .be_next     (be_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= next_state;
        end
    end

    // A sample arriving with the flush is counted before the flush decision.
    always_comb begin
        next_state  = state_q;
        accept      = 1'b0;
        load_word   = 1'b0;
        flush_empty = 1'b0;
        complete    = 1'b0;
        case (state_q)
            ST_FILL: begin
                accept = sample_valid & sample_ready;
                if (fill_count == 3'(LANES)) begin
                    next_state = ST_WRITE;
                    load_word  = 1'b1;
                end else if (flush_req) begin
                    if (fill_count != 3'd0) begin
                        next_state = ST_WRITE;
                        load_word  = 1'b1;
                    end else begin
                        flush_empty = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
                    complete   = 1'b1;
                    next_state = ST_FILL;
                end
            end
            default: next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_ready   <= 1'b0;
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            avm_address    <= '0;
            wr_ptr         <= '0;
            wrap           <= 1'b0;
            flush_done     <= 1'b0;
            flush_pending  <= 1'b0;
            write_is_flush <= 1'b0;
        end else begin
            sample_ready <= (next_state == ST_FILL);
            wrap         <= 1'b0;
            flush_done   <= 1'b0;

            if (load_word) begin
                avm_write      <= 1'b1;
                avm_chipselect <= 1'b1;
                avm_byteenable <= be_next;
                avm_writedata  <= word_next;
                avm_address    <= BASE + wr_ptr;
                write_is_flush <= flush_req;
            end

            if (complete) begin
                avm_write      <= 1'b0;
                avm_chipselect <= 1'b0;
                if (wr_ptr == PTR_MAX) begin
                    wr_ptr <= '0;
                    wrap   <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (write_is_flush) begin
                    flush_done <= 1'b1;
                end
            end

            if (flush_empty) begin
                flush_done <= 1'b1;
            end

            if ((complete && write_is_flush) || flush_empty) begin
                flush_pending <= 1'b0;
            end else if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (sample_valid && !sample_ready) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imu_sample_ram_writer.sv
// Directed/randomized bench for imu_sample_ram_writer with a word-level reference model.
module tb_imu_sample_ram_writer;

    localparam int DEPTH = 1250;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        flush = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic        clear_status = 1'b0;

    logic        sample_ready, flush_done, avm_chipselect, avm_write, wrap, overflow;
    logic [10:0] avm_address, wr_ptr;
    logic [7:0]  avm_byteenable, drop_count;
    logic [63:0] avm_writedata;

    logic        b_sample_ready, b_flush_done, b_avm_chipselect, b_avm_write, b_wrap, b_overflow;
    logic [10:0] b_avm_address, b_wr_ptr;
    logic [7:0]  b_avm_byteenable, b_drop_count;
    logic [63:0] b_avm_writedata;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;
    logic [15:0] smp [4];

    always #5 clk = ~clk;

    imu_sample_ram_writer dut (
        .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .flush(flush), .flush_done(flush_done),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .wr_ptr(wr_ptr), .wrap(wrap),
        .overflow(overflow), .drop_count(drop_count), .clear_status(clear_status)
    );

    imu_sample_ram_writer #(.BASE_ADDR(32'h100)) dut_b (
        .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(b_sample_ready), .flush(flush), .flush_done(b_flush_done),
        .avm_address(b_avm_address), .avm_chipselect(b_avm_chipselect), .avm_write(b_avm_write),
        .avm_byteenable(b_avm_byteenable), .avm_writedata(b_avm_writedata),
        .avm_waitrequest(avm_waitrequest), .wr_ptr(b_wr_ptr), .wrap(b_wrap),
        .overflow(b_overflow), .drop_count(b_drop_count), .clear_status(clear_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {63'd0, sample_ready}, 64'd0);
        chk({tag, "_write"}, {63'd0, avm_write}, 64'd0);
        chk({tag, "_cs"}, {63'd0, avm_chipselect}, 64'd0);
        chk({tag, "_be"}, {56'd0, avm_byteenable}, 64'd0);
        chk({tag, "_data"}, avm_writedata, 64'd0);
        chk({tag, "_addr"}, {53'd0, avm_address}, 64'd0);
        chk({tag, "_fdone"}, {63'd0, flush_done}, 64'd0);
        chk({tag, "_wrap"}, {63'd0, wrap}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_drops"}, {56'd0, drop_count}, 64'd0);
        chk({tag, "_ptr"}, {53'd0, wr_ptr}, 64'd0);
    endtask

    // fmode: 0 = no flush, 1 = flush pulse after the last sample, 2 = flush with the last sample
    task automatic send_word(input int n, input int ws, input int fmode);
        logic [63:0] exp_word;
        logic [7:0]  exp_be;
        logic [63:0] d0;
        logic [10:0] a0;
        logic        exp_wrap;
        int          guard;
        exp_word = '0;
        exp_be   = '0;
        for (int i = 0; i < n; i++) exp_word |= 64'(smp[i]) << (16 * i);
        for (int b = 0; b < 2 * n; b++) exp_be[b] = 1'b1;
        avm_waitrequest = (ws > 0);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = smp[i];
            if (fmode == 2 && i == n - 1) flush = 1'b1;
            guard = 0;
            while (sample_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (guard == 20) chk("ready_timeout", 64'(sample_ready), 64'd1);
            tick();
            flush = 1'b0;
        end
        sample_valid = 1'b0;
        if (fmode == 1) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        chk("w0_write", 64'(avm_write), 64'd1);
        chk("w0_cs", 64'(avm_chipselect), 64'd1);
        chk("w0_ready", 64'(sample_ready), 64'd0);
        chk("w0_addr", 64'(avm_address), 64'(exp_ptr));
        chk("w0_addr_b", 64'(b_avm_address), 64'((exp_ptr + 'h100) % 2048));
        chk("w0_data", avm_writedata, exp_word);
        chk("w0_be", 64'(avm_byteenable), 64'(exp_be));
        d0 = avm_writedata;
        a0 = avm_address;
        for (int i = 1; i <= ws; i++) begin
            tick();
            chk("ws_write", 64'(avm_write), 64'd1);
            chk("ws_ready", 64'(sample_ready), 64'd0);
            chk("ws_addr", 64'(avm_address), 64'(a0));
            chk("ws_data", avm_writedata, d0);
            chk("ws_ptr", 64'(wr_ptr), 64'(exp_ptr));
            if (i == ws) avm_waitrequest = 1'b0;
        end
        tick();
        exp_wrap = (exp_ptr == DEPTH - 1);
        exp_ptr  = (exp_ptr + 1) % DEPTH;
        chk("done_write", 64'(avm_write), 64'd0);
        chk("done_ready", 64'(sample_ready), 64'd1);
        chk("done_ptr", 64'(wr_ptr), 64'(exp_ptr));
        chk("done_ptr_b", 64'(b_wr_ptr), 64'(exp_ptr));
        chk("done_wrap", 64'(wrap), 64'(exp_wrap));
        chk("done_fdone", 64'(flush_done), 64'(fmode != 0));
        tick();
        chk("post_wrap", 64'(wrap), 64'd0);
        chk("post_fdone", 64'(flush_done), 64'd0);
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk("rst_ready_rise", 64'(sample_ready), 64'd1);

        // Two words 0x0001..0x0008
        for (int i = 0; i < 4; i++) smp[i] = 16'(i + 1);
        send_word(4, 0, 0);
        for (int i = 0; i < 4; i++) smp[i] = 16'(i + 5);
        send_word(4, 0, 0);
        chk("ptr_after_two", 64'(wr_ptr), 64'd2);

        // Wait states
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        send_word(4, 3, 0);

        // Partial flush, flush with last sample, full word with flush
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        send_word(3, 0, 1);
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        send_word(2, 1, 2);
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        send_word(4, 0, 2);

        // Flush with nothing packed
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("f0_fdone", 64'(flush_done), 64'd1);
        chk("f0_write", 64'(avm_write), 64'd0);
        tick();
        chk("f0_fdone_end", 64'(flush_done), 64'd0);
        chk("f0_write_end", 64'(avm_write), 64'd0);
        chk("f0_ptr", 64'(wr_ptr), 64'(exp_ptr));

        // A full lap of the buffer
        for (int w = 0; w < DEPTH; w++) begin
            for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
            send_word(4, $urandom_range(0, 2), 0);
        end
        for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
        send_word(4, 0, 0);

        // Drops during a long stall
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp[i] = 16'($urandom);
            sample_valid = 1'b1;
            sample_data  = smp[i];
            chk("drop_fill_ready", 64'(sample_ready), 64'd1);
            tick();
        end
        chk("drop_w0_write", 64'(avm_write), 64'd1);
        chk("drop_w0_data", avm_writedata,
            {smp[3], smp[2], smp[1], smp[0]});
        for (int n = 1; n <= 300; n++) begin
            sample_data = 16'($urandom);
            tick();
            if (n == 10) begin
                chk("drop_cnt10", 64'(drop_count), 64'd10);
                chk("drop_ovf10", 64'(overflow), 64'd1);
            end
        end
        chk("drop_sat", 64'(drop_count), 64'd255);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_write_held", 64'(avm_write), 64'd1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("clr_cnt", 64'(drop_count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        tick();
        chk("after_clr_cnt", 64'(drop_count), 64'd1);
        chk("after_clr_ovf", 64'(overflow), 64'd1);
        sample_valid = 1'b0;
        clear_status = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        clear_status = 1'b0;
        exp_ptr = (exp_ptr + 1) % DEPTH;
        chk("drop_done_ptr", 64'(wr_ptr), 64'(exp_ptr));
        chk("drop_done_cnt", 64'(drop_count), 64'd0);

        // Reset in the middle of a write
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data  = 16'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        chk("mid_write", 64'(avm_write), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        chk_all_zero("midrst");
        exp_ptr = 0;
        tick();
        chk("midrst_ready", 64'(sample_ready), 64'd1);
        smp[0] = 16'($urandom);
        send_word(1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
